// File: rtl/scaler_cfg.sv
// scaler_cfg: frame-synchronous scale-step configuration and video timing counters.
// Ports: clk/rst, cfg_wr_i/cfg_step_i/cfg_busy_o/cfg_applied_o/err_o, hs_i/vs_i/de_i,
//        scale_step_o, line_width_o, line_cnt_o, frame_cnt_o.
module scaler_cfg #(
  parameter int STEP_WIDTH = 16,
  parameter int PIXEL_STEP = 128,
  parameter int MAX_STEP   = 512,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr_i,
  input  logic [STEP_WIDTH-1:0] cfg_step_i,
  output logic                  cfg_busy_o,
  output logic                  cfg_applied_o,
  output logic                  err_o,
  input  logic                  hs_i,
  input  logic                  vs_i,
  input  logic                  de_i,
  output logic [STEP_WIDTH-1:0] scale_step_o,
  output logic [CNT_WIDTH-1:0]  line_width_o,
  output logic [CNT_WIDTH-1:0]  line_cnt_o,
  output logic [CNT_WIDTH-1:0]  frame_cnt_o
);

  localparam logic [STEP_WIDTH-1:0] STEP_ONE =
    STEP_WIDTH'(PIXEL_STEP);
  localparam logic [STEP_WIDTH-1:0] STEP_MAX =
    STEP_WIDTH'(MAX_STEP);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [STEP_WIDTH-1:0]   shadow;
  logic [STEP_WIDTH-1:0]   shadow_n;
  logic [STEP_WIDTH-1:0]   step_n;
  logic                    applied_n;
  logic                    err_n;
  logic                    wr_ok;
  logic                    wr_bad;

  logic [CNT_WIDTH-1:0]    pix_cnt;
  logic [CNT_WIDTH-1:0]    pix_inc;

  assign wr_ok  = cfg_wr_i
               && (cfg_step_i != '0)
               && (cfg_step_i <= STEP_MAX);
  assign wr_bad = cfg_wr_i && !wr_ok;

  // state is a flop, so busy is registered as well
  assign cfg_busy_o = (state == PEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shadow        <= STEP_ONE;
      scale_step_o  <= STEP_ONE;
      cfg_applied_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state         <= state_n;
      shadow        <= shadow_n;
      scale_step_o  <= step_n;
      cfg_applied_o <= applied_n;
      err_o         <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    shadow_n  = shadow;
    step_n    = scale_step_o;
    applied_n = 1'b0;
    err_n     = err_o | wr_bad;
    unique case (state)
      IDLE: begin
        // a write landing on vs only arms the
        // next frame; nothing is applied now
        if (wr_ok) begin
          shadow_n = cfg_step_i;
          state_n  = PEND;
        end
      end
      PEND: begin
        if (vs_i) begin
          step_n    = shadow;
          applied_n = 1'b1;
          state_n   = IDLE;
        end
        // old shadow is applied above, the new
        // write stays pending for the next frame
        if (wr_ok) begin
          shadow_n = cfg_step_i;
          state_n  = PEND;
        end
      end
    endcase
  end

  // pixel count including a de_i in this cycle
  assign pix_inc = pix_cnt + CNT_WIDTH'(de_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt      <= '0;
      line_width_o <= '0;
    end else if (hs_i) begin
      line_width_o <= pix_inc;
      pix_cnt      <= CNT_WIDTH'(de_i);
    end else begin
      pix_cnt      <= pix_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt_o <= '0;
    end else if (hs_i && vs_i) begin
      line_cnt_o <= '0;
    end else if (hs_i) begin
      line_cnt_o <= line_cnt_o + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_o <= '0;
    end else if (vs_i) begin
      frame_cnt_o <= frame_cnt_o + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_scaler_cfg.sv
// tb_scaler_cfg: scoreboard bench for scaler_cfg.
// Expected applied steps are queued when vs_i is driven, popped on cfg_applied_o.
module tb_scaler_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr_i = 1'b0;
  logic [15:0] cfg_step_i = '0;
  logic        cfg_busy_o;
  logic        cfg_applied_o;
  logic        err_o;
  logic        hs_i = 1'b0;
  logic        vs_i = 1'b0;
  logic        de_i = 1'b0;
  logic [15:0] scale_step_o;
  logic [15:0] line_width_o;
  logic [15:0] line_cnt_o;
  logic [15:0] frame_cnt_o;

  int vectors = 0;
  int errs    = 0;
  int n_applied = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  scaler_cfg dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr_i     (cfg_wr_i),
    .cfg_step_i   (cfg_step_i),
    .cfg_busy_o   (cfg_busy_o),
    .cfg_applied_o(cfg_applied_o),
    .err_o        (err_o),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
    .de_i         (de_i),
    .scale_step_o (scale_step_o),
    .line_width_o (line_width_o),
    .line_cnt_o   (line_cnt_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  // scoreboard: every applied pulse must match the oldest queued step
  always @(negedge clk) begin
    if (cfg_applied_o === 1'b1) begin
      n_applied++;
      vectors++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL sb_unexpected: applied step %0d, none queued",
                 scale_step_o);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (scale_step_o !== e) begin
          errs++;
          $display("FAIL sb_step: got %0d want %0d", scale_step_o, e);
        end
      end
    end
  end

  // inputs change on negedge, outputs are read one negedge later
  task automatic tick(input logic wr, input logic [15:0] st,
                      input logic h, input logic v, input logic d);
    cfg_wr_i   = wr;
    cfg_step_i = st;
    hs_i       = h;
    vs_i       = v;
    de_i       = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 16'd300, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (scale_step_o !== 16'd128 || cfg_busy_o !== 1'b0 ||
        cfg_applied_o !== 1'b0 || err_o !== 1'b0) begin
      errs++;
      $display("FAIL reset_cfg: step=%0d busy=%0b app=%0b err=%0b want 128/0/0/0",
               scale_step_o, cfg_busy_o, cfg_applied_o, err_o);
    end
    vectors++;
    if (line_width_o !== 16'd0 || line_cnt_o !== 16'd0 ||
        frame_cnt_o !== 16'd0) begin
      errs++;
      $display("FAIL reset_cnt: w=%0d l=%0d f=%0d want 0/0/0",
               line_width_o, line_cnt_o, frame_cnt_o);
    end
    tick(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(2);
    vectors++;
    if (scale_step_o !== 16'd128 || cfg_busy_o !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: step=%0d busy=%0b want 128/0",
               scale_step_o, cfg_busy_o);
    end
  endtask

  task automatic test_apply;
    int n0;
    n0 = n_applied;
    tick(1'b1, 16'd179, 1'b0, 1'b0, 1'b1);
    idle(4);
    vectors++;
    if (cfg_busy_o !== 1'b1 || scale_step_o !== 16'd128) begin
      errs++;
      $display("FAIL apply_pend: busy=%0b step=%0d want 1/128",
               cfg_busy_o, scale_step_o);
    end
    exp_q.push_back(16'd179);
    tick(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (cfg_applied_o !== 1'b1 || cfg_busy_o !== 1'b0 ||
        scale_step_o !== 16'd179) begin
      errs++;
      $display("FAIL apply_vs: app=%0b busy=%0b step=%0d want 1/0/179",
               cfg_applied_o, cfg_busy_o, scale_step_o);
    end
    idle(1);
    vectors++;
    if (cfg_applied_o !== 1'b0) begin
      errs++;
      $display("FAIL apply_pulse: app=%0b want 0", cfg_applied_o);
    end
    idle(2);
    vectors++;
    if (n_applied !== n0 + 1) begin
      errs++;
      $display("FAIL apply_count: got %0d want %0d", n_applied - n0, 1);
    end
  endtask

  task automatic test_last_wins;
    int n0;
    n0 = n_applied;
    tick(1'b1, 16'd100, 1'b0, 1'b0, 1'b0);
    idle(2);
    tick(1'b1, 16'd150, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 16'd200, 1'b0, 1'b0, 1'b0);
    idle(2);
    vectors++;
    if (scale_step_o !== 16'd179 || cfg_busy_o !== 1'b1) begin
      errs++;
      $display("FAIL last_hold: step=%0d busy=%0b want 179/1",
               scale_step_o, cfg_busy_o);
    end
    exp_q.push_back(16'd200);
    tick(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    idle(4);
    tick(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    idle(2);
    vectors++;
    if (n_applied !== n0 + 1 || scale_step_o !== 16'd200) begin
      errs++;
      $display("FAIL last_wins: pulses=%0d step=%0d want 1/200",
               n_applied - n0, scale_step_o);
    end
  endtask

  task automatic test_invalid;
    int n0;
    n0 = n_applied;
    tick(1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err_o !== 1'b1 || cfg_busy_o !== 1'b0) begin
      errs++;
      $display("FAIL inv_zero: err=%0b busy=%0b want 1/0", err_o, cfg_busy_o);
    end
    idle(3);
    tick(1'b1, 16'd600, 1'b0, 1'b0, 1'b0);
    idle(3);
    tick(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    idle(3);
    vectors++;
    if (err_o !== 1'b1 || cfg_busy_o !== 1'b0 ||
        scale_step_o !== 16'd200 || n_applied !== n0) begin
      errs++;
      $display("FAIL inv_600: err=%0b busy=%0b step=%0d pulses=%0d want 1/0/200/0",
               err_o, cfg_busy_o, scale_step_o, n_applied - n0);
    end
  endtask

  task automatic test_bounds;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    tick(1'b1, 16'd513, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err_o !== 1'b1 || cfg_busy_o !== 1'b0) begin
      errs++;
      $display("FAIL bound_513: err=%0b busy=%0b want 1/0", err_o, cfg_busy_o);
    end
    tick(1'b1, 16'd512, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (cfg_busy_o !== 1'b1) begin
      errs++;
      $display("FAIL bound_512: busy=%0b want 1", cfg_busy_o);
    end
    tick(1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(16'd1);
    tick(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (scale_step_o !== 16'd1 || cfg_busy_o !== 1'b0) begin
      errs++;
      $display("FAIL bound_1: step=%0d busy=%0b want 1/0",
               scale_step_o, cfg_busy_o);
    end
    idle(2);
  endtask

  task automatic test_vs_idle;
    int n0;
    n0 = n_applied;
    tick(1'b1, 16'd160, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (cfg_busy_o !== 1'b1 || cfg_applied_o !== 1'b0 ||
        scale_step_o !== 16'd1) begin
      errs++;
      $display("FAIL vsidle_hold: busy=%0b app=%0b step=%0d want 1/0/1",
               cfg_busy_o, cfg_applied_o, scale_step_o);
    end
    for (int l = 0; l < 3; l++) begin
      tick(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
      idle(3);
    end
    vectors++;
    if (scale_step_o !== 16'd1 || n_applied !== n0) begin
      errs++;
      $display("FAIL vsidle_frame: step=%0d pulses=%0d want 1/0",
               scale_step_o, n_applied - n0);
    end
    exp_q.push_back(16'd160);
    tick(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    idle(2);
    vectors++;
    if (scale_step_o !== 16'd160 || n_applied !== n0 + 1) begin
      errs++;
      $display("FAIL vsidle_next: step=%0d pulses=%0d want 160/1",
               scale_step_o, n_applied - n0);
    end
  endtask

  task automatic test_vs_pend;
    tick(1'b1, 16'd90, 1'b0, 1'b0, 1'b0);
    idle(2);
    exp_q.push_back(16'd90);
    tick(1'b1, 16'd70, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (scale_step_o !== 16'd90 || cfg_applied_o !== 1'b1 ||
        cfg_busy_o !== 1'b1) begin
      errs++;
      $display("FAIL vspend_old: step=%0d app=%0b busy=%0b want 90/1/1",
               scale_step_o, cfg_applied_o, cfg_busy_o);
    end
    idle(3);
    exp_q.push_back(16'd70);
    tick(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (scale_step_o !== 16'd70 || cfg_busy_o !== 1'b0) begin
      errs++;
      $display("FAIL vspend_new: step=%0d busy=%0b want 70/0",
               scale_step_o, cfg_busy_o);
    end
    idle(2);
  endtask

  task automatic test_rst_pend;
    int n0;
    tick(1'b1, 16'd256, 1'b0, 1'b0, 1'b0);
    idle(1);
    rst = 1'b1;
    tick(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    idle(1);
    n0 = n_applied;
    vectors++;
    if (scale_step_o !== 16'd128 || cfg_busy_o !== 1'b0 ||
        err_o !== 1'b0) begin
      errs++;
      $display("FAIL rstpend_clr: step=%0d busy=%0b err=%0b want 128/0/0",
               scale_step_o, cfg_busy_o, err_o);
    end
    tick(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    idle(3);
    vectors++;
    if (scale_step_o !== 16'd128 || n_applied !== n0) begin
      errs++;
      $display("FAIL rstpend_vs: step=%0d pulses=%0d want 128/0",
               scale_step_o, n_applied - n0);
    end
  endtask

  task automatic test_counters;
    logic [15:0] exp_w;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    // de_i on the hs_i cycle counts toward the closing line
    for (int i = 0; i < 3; i++) tick(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (line_width_o !== 16'd4) begin
      errs++;
      $display("FAIL cnt_hs_de: width=%0d want 4", line_width_o);
    end
    tick(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (line_width_o !== 16'd2 || line_cnt_o !== 16'd2) begin
      errs++;
      $display("FAIL cnt_restart: width=%0d line=%0d want 2/2",
               line_width_o, line_cnt_o);
    end
    exp_w = 16'd0;
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 24; l++) begin
        tick(1'b0, 16'd0, 1'b1, (l == 0), 1'b0);
        vectors++;
        if (line_cnt_o !== 16'(l) || line_width_o !== exp_w) begin
          errs++;
          $display("FAIL cnt_line f%0d l%0d: line=%0d width=%0d want %0d/%0d",
                   f, l, line_cnt_o, line_width_o, l, exp_w);
        end
        exp_w = 16'd24;
        for (int p = 0; p < 24; p++) begin
          tick(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
          if (f == 1) idle(3);
        end
        idle(2);
      end
    end
    tick(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (line_width_o !== 16'd24 || frame_cnt_o !== 16'd2 ||
        line_cnt_o !== 16'd24) begin
      errs++;
      $display("FAIL cnt_end: width=%0d frames=%0d line=%0d want 24/2/24",
               line_width_o, frame_cnt_o, line_cnt_o);
    end
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_apply();
    test_last_wins();
    test_invalid();
    test_bounds();
    test_vs_idle();
    test_vs_pend();
    test_rst_pend();
    test_counters();
    idle(2);
    vectors++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL sb_leftover: %0d queued steps never applied",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/scaler_cfg.md
SCALER_CFG -- requirements
Module: scaler_cfg

Interface
REQ-001 Parameter STEP_WIDTH, default 16, width of scale step words.
REQ-002 Parameter PIXEL_STEP, default 128, step value for scale 1.0.
REQ-003 Parameter MAX_STEP, default 512, largest accepted step (4x scale down).
REQ-004 Parameter CNT_WIDTH, default 16, width of line, pixel and frame counters.
REQ-005 Port clk, input, 1, single clock for all logic; one clock domain, no other clocks.
REQ-006 Port rst, input, 1, reset; synchronous, active-high.
REQ-007 Port cfg_wr_i, input, 1, one-cycle write strobe for a new step.
REQ-008 Port cfg_step_i, input, STEP_WIDTH, requested step, sampled when cfg_wr_i=1.
REQ-009 Port cfg_busy_o, output, 1, high while an accepted step is pending.
REQ-010 Port cfg_applied_o, output, 1, one-cycle pulse when a pending step is applied.
REQ-011 Port err_o, output, 1, sticky flag for a rejected write.
REQ-012 Port hs_i, input, 1, one-cycle pulse at line start (scaler input timing).
REQ-013 Port vs_i, input, 1, one-cycle pulse at frame start, coincident with the first hs_i of the frame.
REQ-014 Port de_i, input, 1, pixel valid.
REQ-015 Port scale_step_o, output, STEP_WIDTH, step driven to the scaler.
REQ-016 Port line_width_o, output, CNT_WIDTH, de_i count of the last completed line.
REQ-017 Port line_cnt_o, output, CNT_WIDTH, current line index in the frame.
REQ-018 Port frame_cnt_o, output, CNT_WIDTH, frames seen since reset.

Function
REQ-019 The FSM SHALL have exactly two states, IDLE and PEND; cfg_busy_o SHALL be 1 only in PEND.
REQ-020 A write is valid when 1 <= cfg_step_i <= MAX_STEP.
REQ-021 A valid write SHALL load the shadow register and move the FSM to PEND on the next clk edge.
REQ-022 An invalid write (0 or >MAX_STEP) SHALL be ignored and SHALL set err_o next cycle; err_o SHALL hold until rst.
REQ-023 In PEND, a further valid write SHALL overwrite the shadow register (last write wins) and the FSM SHALL stay in PEND.
REQ-024 In PEND, vs_i=1 SHALL, at the next edge, copy the shadow register to scale_step_o, pulse cfg_applied_o for 1 cycle, and move the FSM to IDLE.
REQ-025 scale_step_o SHALL never change except per REQ-024 or rst, so the step stays constant for a whole frame.
REQ-026 Valid write and vs_i in the same cycle, FSM in PEND: vs_i applies the old shadow value; the new value loads the shadow; the FSM stays in PEND; cfg_applied_o pulses.
REQ-027 Valid write and vs_i in the same cycle, FSM in IDLE: nothing is applied; the FSM enters PEND; the value applies at the following vs_i.
REQ-028 The pixel counter SHALL increment on de_i=1.
REQ-029 On hs_i=1, line_width_o SHALL take the pixel count (including a de_i in that same cycle) and the counter SHALL restart at 0, or at 1 if de_i=1 in that cycle.
REQ-030 line_cnt_o SHALL go to 0 on hs_i&vs_i, increment on hs_i alone, and wrap at 2^CNT_WIDTH.
REQ-031 frame_cnt_o SHALL increment on vs_i and wrap at 2^CNT_WIDTH.
REQ-032 All outputs SHALL be registered; latency from input event to output is 1 clk.
REQ-033 All behaviour is correct for any de_i duty cycle (0, 1, or 3 idle cycles per pixel) and for any line gap.

Reset
REQ-034 While rst=1 the block SHALL drive: scale_step_o=PIXEL_STEP, FSM=IDLE, cfg_busy_o=0, cfg_applied_o=0, err_o=0, all counters and line_width_o=0, shadow register=PIXEL_STEP.
REQ-035 rst asserted in PEND SHALL discard the pending step; after release scale_step_o=PIXEL_STEP and no cfg_applied_o pulse occurs.
REQ-036 Inputs SHALL be ignored in any cycle where rst=1.

Verification
REQ-037 Write 179 mid-frame, then vs_i -> cfg_busy_o=1 until vs_i; scale_step_o=179 and cfg_applied_o pulse one cycle after vs_i.
REQ-038 Writes 100, 150, 200 in one frame -> only 200 is applied at the next vs_i; exactly one cfg_applied_o pulse.
REQ-039 Write 0, then write 600 -> err_o=1 and stays 1; scale_step_o unchanged; cfg_busy_o stays 0.
REQ-040 Write 160 coincident with vs_i in IDLE -> no change that frame; 160 applied at the next vs_i.
REQ-041 Two frames of 24 lines x 24 pixels, DE_I_PERIOD 0 and 4 -> line_width_o=24, line_cnt_o 0..23, frame_cnt_o=2.
REQ-042 Write 256, then rst pulse before vs_i -> scale_step_o=128, cfg_busy_o=0, no apply at the next vs_i.
